// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the scan controller, its display-data source and the shared
// BCD decoder / digit drivers.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                          en;
    logic [4*NUM_DIGITS-1:0]       data;
    logic                          lamp_req;
    logic [3:0]                    dec_a;
    logic                          dec_lt_n;
    logic                          dec_bi_n;
    logic                          dec_le;
    logic [NUM_DIGITS-1:0]         dig_sel;
    logic [$clog2(NUM_DIGITS)-1:0] scan_idx;
    logic                          frame_done;

    modport master (
        output en, data, lamp_req,
        input  dec_a, dec_lt_n, dec_bi_n, dec_le, dig_sel, scan_idx, frame_done
    );

    modport slave (
        input  en, data, lamp_req,
        output dec_a, dec_lt_n, dec_bi_n, dec_le, dig_sel, scan_idx, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: BLANK -> LOAD -> SHOW per digit, plus timed lamp test.
// Optional leading-zero suppression when SEG_SCAN_LEAD_ZERO_BLANK_EN is defined.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLANK_CYC  = 16,
    parameter int unsigned LAMP_CYC   = 50000
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
    localparam int unsigned SHOW_CYC = SCAN_DIV - BLANK_CYC - 1;
    localparam int unsigned CNT_MAX  = (SCAN_DIV > LAMP_CYC) ? SCAN_DIV : LAMP_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] LAMP_LAST  = CNT_W'(LAMP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StBlank, StLoad, StShow, StLamp} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            dec_a_q, dec_a_d;
    logic                  supp_q, supp_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  bi_n_q, bi_n_d;
    logic                  lt_n_q, lt_n_d;
    logic                  le_q, le_d;
    logic                  fd_q, fd_d;
    logic [3:0]            load_nib;
    logic                  supp_load;

    always_comb begin
        load_nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) load_nib = bus.data[4*i +: 4];
        end
    end

`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
    logic upper_nz;

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) >= idx_q && bus.data[4*i +: 4] != 4'h0) upper_nz = 1'b1;
        end
        supp_load = (idx_q != '0) && !upper_nz;
    end
`else
    assign supp_load = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        dec_a_d = dec_a_q;
        supp_d  = supp_q;
        if (!bus.en) begin
            state_d = StBlank;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (bus.lamp_req && state_q != StLamp) begin
            state_d = StLamp;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StBlank: if (cnt_q == BLANK_LAST) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    dec_a_d = load_nib;
                    supp_d  = supp_load;
                end
                StLoad: begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
                StShow: if (cnt_q == SHOW_LAST) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
                StLamp: if (cnt_q == LAMP_LAST) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                default: state_d = StBlank;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered values track the state register.
    always_comb begin
        dig_sel_d = '0;
        bi_n_d    = 1'b0;
        lt_n_d    = 1'b1;
        le_d      = 1'b0;
        fd_d      = 1'b0;
        unique case (state_d)
            StBlank: ;
            StLoad:  bi_n_d = 1'b1;
            StShow: begin
                le_d      = 1'b1;
                bi_n_d    = !supp_d;
                dig_sel_d = supp_d ? '0 : (NUM_DIGITS'(1) << idx_d);
                fd_d      = (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
            end
            StLamp: begin
                lt_n_d    = 1'b0;
                bi_n_d    = 1'b1;
                dig_sel_d = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StBlank;
            idx_q     <= '0;
            cnt_q     <= '0;
            dec_a_q   <= '0;
            supp_q    <= 1'b0;
            dig_sel_q <= '0;
            bi_n_q    <= 1'b0;
            lt_n_q    <= 1'b1;
            le_q      <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dec_a_q   <= dec_a_d;
            supp_q    <= supp_d;
            dig_sel_q <= dig_sel_d;
            bi_n_q    <= bi_n_d;
            lt_n_q    <= lt_n_d;
            le_q      <= le_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.dec_a      = dec_a_q;
    assign bus.dec_lt_n   = lt_n_q;
    assign bus.dec_bi_n   = bi_n_q;
    assign bus.dec_le     = le_q;
    assign bus.dig_sel    = dig_sel_q;
    assign bus.scan_idx   = idx_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, LAMP_CYC=5.
module tb_seg_scan_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) dut_if ();

    seg_scan_ctrl #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .LAMP_CYC  (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dut_if.en = 1'b0;
        dut_if.lamp_req = 1'b0;
        dut_if.data = 16'h4321;
        tick();
        tick();
        total++; if (dut_if.dig_sel !== 4'h0) begin bad++; $display("FAIL reset dig_sel got=%b exp=0000", dut_if.dig_sel); end
        total++; if (dut_if.dec_a !== 4'h0) begin bad++; $display("FAIL reset dec_a got=%h exp=0", dut_if.dec_a); end
        total++; if (dut_if.dec_bi_n !== 1'b0) begin bad++; $display("FAIL reset bi_n got=%b exp=0", dut_if.dec_bi_n); end
        total++; if (dut_if.dec_lt_n !== 1'b1) begin bad++; $display("FAIL reset lt_n got=%b exp=1", dut_if.dec_lt_n); end
        total++; if (dut_if.dec_le !== 1'b0) begin bad++; $display("FAIL reset le got=%b exp=0", dut_if.dec_le); end
        total++; if (dut_if.scan_idx !== 2'd0) begin bad++; $display("FAIL reset scan_idx got=%0d exp=0", dut_if.scan_idx); end
        total++; if (dut_if.frame_done !== 1'b0) begin bad++; $display("FAIL reset frame_done got=%b exp=0", dut_if.frame_done); end
        rst = 1'b0;
        dut_if.en = 1'b1;
    endtask

    // Two full frames of 4321: slot = t/8, phase 0-1 blank, 2 load, 3-7 show.
    task automatic test_scan();
        int slot, ph;
        logic [3:0] es;
        for (int t = 1; t < 64; t++) begin
            tick();
            slot = (t / 8) % 4;
            ph = t % 8;
            es = (ph >= 3) ? (4'b0001 << slot) : 4'h0;
            total++; if (dut_if.dig_sel !== es) begin bad++; $display("FAIL scan dig_sel t=%0d got=%b exp=%b", t, dut_if.dig_sel, es); end
            total++; if (dut_if.scan_idx !== 2'(slot)) begin bad++; $display("FAIL scan idx t=%0d got=%0d exp=%0d", t, dut_if.scan_idx, slot); end
            total++; if (dut_if.dec_bi_n !== (ph >= 2)) begin bad++; $display("FAIL scan bi_n t=%0d got=%b", t, dut_if.dec_bi_n); end
            total++; if (dut_if.dec_le !== (ph >= 3)) begin bad++; $display("FAIL scan le t=%0d got=%b", t, dut_if.dec_le); end
            total++; if (dut_if.frame_done !== (t % 32 == 31)) begin bad++; $display("FAIL scan frame_done t=%0d got=%b", t, dut_if.frame_done); end
            if (ph >= 2) begin
                total++; if (dut_if.dec_a !== 4'(slot + 1)) begin bad++; $display("FAIL scan dec_a t=%0d got=%h exp=%0d", t, dut_if.dec_a, slot + 1); end
            end
        end
    endtask

    // data switches to 4391 mid-SHOW of idx 1 (t=76); visible only from the next frame.
    task automatic test_data_change();
        int slot, ph;
        logic [3:0] ea;
        for (int t = 64; t < 128; t++) begin
            tick();
            slot = (t / 8) % 4;
            ph = t % 8;
            ea = 4'(slot + 1);
            if (slot == 1 && t >= 96) ea = 4'h9;
            if (ph >= 2) begin
                total++; if (dut_if.dec_a !== ea) begin bad++; $display("FAIL datachg dec_a t=%0d got=%h exp=%h", t, dut_if.dec_a, ea); end
            end
            if (t == 76) dut_if.data = 16'h4391;
        end
    endtask

    task automatic test_lamp();
        int slot, ph;
        logic [3:0] es;
        logic [3:0] ea;
        logic [15:0] d;
        d = 16'h4391;
        for (int t = 128; t < 148; t++) tick();
        dut_if.lamp_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            dut_if.lamp_req = (k == 2);  // repeat request inside LAMP must not restart it
            total++; if (dut_if.dec_lt_n !== 1'b0) begin bad++; $display("FAIL lamp lt_n k=%0d got=%b exp=0", k, dut_if.dec_lt_n); end
            total++; if (dut_if.dig_sel !== 4'hf) begin bad++; $display("FAIL lamp dig_sel k=%0d got=%b exp=1111", k, dut_if.dig_sel); end
            total++; if (dut_if.dec_bi_n !== 1'b1 || dut_if.dec_le !== 1'b0) begin bad++; $display("FAIL lamp bi_n/le k=%0d got=%b/%b exp=1/0", k, dut_if.dec_bi_n, dut_if.dec_le); end
        end
        dut_if.lamp_req = 1'b0;
        tick();
        total++; if (dut_if.dig_sel !== 4'h0 || dut_if.dec_lt_n !== 1'b1) begin bad++; $display("FAIL lamp_exit sel/lt_n got=%b/%b exp=0000/1", dut_if.dig_sel, dut_if.dec_lt_n); end
        total++; if (dut_if.scan_idx !== 2'd0) begin bad++; $display("FAIL lamp_exit scan_idx got=%0d exp=0", dut_if.scan_idx); end
        for (int t = 1; t < 32; t++) begin
            tick();
            slot = t / 8;
            ph = t % 8;
            es = (ph >= 3) ? (4'b0001 << slot) : 4'h0;
            ea = d[4*slot +: 4];
            total++; if (dut_if.dig_sel !== es) begin bad++; $display("FAIL post_lamp dig_sel t=%0d got=%b exp=%b", t, dut_if.dig_sel, es); end
            total++; if (dut_if.frame_done !== (t == 31)) begin bad++; $display("FAIL post_lamp frame_done t=%0d got=%b", t, dut_if.frame_done); end
            if (ph >= 2) begin
                total++; if (dut_if.dec_a !== ea) begin bad++; $display("FAIL post_lamp dec_a t=%0d got=%h exp=%h", t, dut_if.dec_a, ea); end
            end
        end
    endtask

    task automatic test_en_drop();
        for (int t = 32; t <= 58; t++) tick();
        total++; if (dut_if.scan_idx !== 2'd3 || dut_if.dec_a !== 4'h4 || dut_if.dec_bi_n !== 1'b1) begin bad++; $display("FAIL en_drop load idx/a/bi_n got=%0d/%h/%b exp=3/4/1", dut_if.scan_idx, dut_if.dec_a, dut_if.dec_bi_n); end
        dut_if.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (dut_if.dig_sel !== 4'h0 || dut_if.scan_idx !== 2'd0) begin bad++; $display("FAIL en_off k=%0d sel/idx got=%b/%0d exp=0000/0", k, dut_if.dig_sel, dut_if.scan_idx); end
            total++; if (dut_if.dec_bi_n !== 1'b0 || dut_if.dec_le !== 1'b0) begin bad++; $display("FAIL en_off k=%0d bi_n/le got=%b/%b exp=0/0", k, dut_if.dec_bi_n, dut_if.dec_le); end
        end
        dut_if.en = 1'b1;
        dut_if.lamp_req = 1'b1;
        tick();
        dut_if.lamp_req = 1'b0;
        total++; if (dut_if.dec_lt_n !== 1'b0 || dut_if.dig_sel !== 4'hf) begin bad++; $display("FAIL en_rise_lamp lt_n/sel got=%b/%b exp=0/1111", dut_if.dec_lt_n, dut_if.dig_sel); end
    endtask

    task automatic test_rst_mid_lamp();
        tick();
        tick();
        total++; if (dut_if.dec_lt_n !== 1'b0) begin bad++; $display("FAIL pre_rst lamp lt_n got=%b exp=0", dut_if.dec_lt_n); end
        rst = 1'b1;
        tick();
        total++; if (dut_if.dig_sel !== 4'h0 || dut_if.dec_a !== 4'h0) begin bad++; $display("FAIL rst_lamp sel/a got=%b/%h exp=0000/0", dut_if.dig_sel, dut_if.dec_a); end
        total++; if (dut_if.dec_lt_n !== 1'b1 || dut_if.dec_bi_n !== 1'b0 || dut_if.dec_le !== 1'b0) begin bad++; $display("FAIL rst_lamp lt_n/bi_n/le got=%b/%b/%b exp=1/0/0", dut_if.dec_lt_n, dut_if.dec_bi_n, dut_if.dec_le); end
        total++; if (dut_if.scan_idx !== 2'd0 || dut_if.frame_done !== 1'b0) begin bad++; $display("FAIL rst_lamp idx/fd got=%0d/%b exp=0/0", dut_if.scan_idx, dut_if.frame_done); end
        rst = 1'b0;
        tick();
        total++; if (dut_if.dec_bi_n !== 1'b0) begin bad++; $display("FAIL rst_restart blank bi_n got=%b exp=0", dut_if.dec_bi_n); end
        tick();
        total++; if (dut_if.dec_a !== 4'h1 || dut_if.dec_bi_n !== 1'b1 || dut_if.scan_idx !== 2'd0) begin bad++; $display("FAIL rst_restart load a/bi_n/idx got=%h/%b/%0d exp=1/1/0", dut_if.dec_a, dut_if.dec_bi_n, dut_if.scan_idx); end
        tick();
        total++; if (dut_if.dig_sel !== 4'b0001 || dut_if.dec_le !== 1'b1) begin bad++; $display("FAIL rst_restart show sel/le got=%b/%b exp=0001/1", dut_if.dig_sel, dut_if.dec_le); end
    endtask

`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
    task automatic test_lead_zero();
        int slot, ph;
        logic [3:0] es;
        logic [15:0] d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d = 16'h0050;
        dut_if.data = d;
        for (int t = 1; t < 64; t++) begin
            tick();
            slot = (t / 8) % 4;
            ph = t % 8;
            es = (ph >= 3 && (slot == 0 || (t < 32 && slot == 1))) ? (4'b0001 << slot) : 4'h0;
            total++; if (dut_if.dig_sel !== es) begin bad++; $display("FAIL lz dig_sel t=%0d got=%b exp=%b", t, dut_if.dig_sel, es); end
            if (ph >= 3) begin
                total++; if (dut_if.dec_bi_n !== (es != 4'h0)) begin bad++; $display("FAIL lz bi_n t=%0d got=%b", t, dut_if.dec_bi_n); end
            end
            if (ph >= 2 && es != 4'h0) begin
                total++; if (dut_if.dec_a !== d[4*slot +: 4]) begin bad++; $display("FAIL lz dec_a t=%0d got=%h exp=%h", t, dut_if.dec_a, d[4*slot +: 4]); end
            end
            total++; if (dut_if.frame_done !== (t % 32 == 31)) begin bad++; $display("FAIL lz frame_done t=%0d got=%b", t, dut_if.frame_done); end
            if (t == 31) begin
                d = 16'h0000;
                dut_if.data = d;
            end
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        dut_if.en = 1'b0;
        dut_if.lamp_req = 1'b0;
        dut_if.data = '0;
        test_reset();
        test_scan();
        test_data_change();
        test_lamp();
        test_en_drop();
        test_rst_mid_lamp();
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
        test_lead_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
